popcount_rr_sched: RTL and testbench
====================================

Name: popcount_rr_sched

Overview:
- Time-shares a single combinational popcount64 datapath between NUM_REQ requesters on the binary-convolution path.
- Each requester presents a burst of 64-bit words, with a last flag on the final word.
- The scheduler grants one requester at a time in round-robin order and holds the grant for the whole burst.
- It accumulates the set-bit count of every word in the burst and returns one tagged result per burst over a valid/ready interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- ACC_W, 16, accumulator and result-count width (>= 7).
- WCNT_W, 10, width of the burst word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*64  per-requester word; requester k occupies bits [64k+63:64k].
- req_last  in  NUM_REQ  per-requester last-word-of-burst flag.
- req_ready  out  NUM_REQ  per-requester word accept.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_count  out  ACC_W  total set bits in the burst.
- res_words  out  WCNT_W  number of words in the burst.
- res_id  out  ID_W  index of the granted requester.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset values (asynchronous, rst_n low):
  - State IDLE; all outputs 0.
  - Accumulator 0, word counter 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- State IDLE:
  - req_ready is all zero.
  - If any req_valid is high, select the first requester with req_valid set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - Register that index as grant, clear accumulator and word counter, and go to ACCUM next cycle.
  - Arbitration itself takes 1 cycle; no word is accepted in IDLE.
- State ACCUM:
  - req_ready[grant]=1; every other requester's ready is 0.
  - On req_valid[grant] && req_ready[grant]:
    - acc <= acc + popcount64(word); popcount width 7, zero-extended.
    - wcnt <= wcnt + 1.
  - If req_last[grant] is also set in that handshake:
    - load res_count = acc + pop and res_words = wcnt + 1;
    - set res_id = grant and res_valid = 1;
    - go to OUT.
  - Latency: last-word handshake in cycle t gives res_valid high at t+1.
  - Throughput: 1 word/cycle while valid is held high.
  - Bubbles (req_valid low) are allowed; state and accumulators hold.
  - Other requesters' valid/data/last are ignored in this state.
- State OUT:
  - req_ready is all zero.
  - res_valid, res_count, res_words and res_id are held stable until res_ready is high.
  - On res_valid && res_ready: res_valid <= 0, last_grant <= grant, next state IDLE.
- Minimum per-burst overhead: 1 IDLE cycle plus 1 OUT cycle.
- A requester dropping req_valid mid-burst does not release the grant; the burst ends only on last.
- Width rules:
  - The accumulator wraps modulo 2**ACC_W (unless POPCNT_SAT_EN is defined).
  - The word counter wraps modulo 2**WCNT_W.
- Single-word bursts are legal: valid and last in the first ACCUM handshake.
- Reset mid-burst or mid-OUT: the burst and any pending result are discarded and all state returns to reset values; requesters must restart the burst.
- All outputs are registered except req_ready, which is decoded from state and grant with no combinational path from req_valid.

Optional Feature:
- Macro: POPCNT_SAT_EN.
- Defined: the accumulator saturates at 2**ACC_W-1. A sticky res_sat output (1 bit, reset 0) is set when any addition in the burst would have overflowed; it is valid with res_valid and cleared on entry to ACCUM.
- Undefined: the accumulator wraps and the res_sat port is absent.

Test Plan:
- Single requester, NUM_REQ=4, req 2 sends 3 words:
  - 0x0, 0x1, 0xFFFFFFFFFFFFFFFF (last) -> res_count=65, res_words=3, res_id=2;
  - res_valid rises exactly 1 cycle after the last handshake.
- Round-robin:
  - all 4 requesters hold valid with 1-word bursts of 0x3 -> grants in order 0,1,2,3,0, each res_count=2;
  - with only req 1 and req 3 active after req 1 is served -> next grant is 3.
- Back-pressure:
  - res_ready held low 5 cycles in OUT -> res_* stable and req_ready all zero throughout;
  - a competing requester is not granted until the result is accepted.
- Bubbles and grant lock:
  - granted req 0 drops valid for 3 cycles mid-burst while req 1 is valid -> req_ready[1] stays 0, and req 0's final count equals the sum over its words only;
  - 0xAAAA_AAAA_AAAA_AAAA x2 -> 64.
- Wrap/saturation, ACC_W=8: 5 all-ones words ->
  - res_count=64 without POPCNT_SAT_EN;
  - res_count=255 and res_sat=1 with POPCNT_SAT_EN.
- Reset mid-burst:
  - rst_n low for 1 cycle after 2 accepted words -> busy=0, res_valid=0, req_ready all zero immediately;
  - the next burst from req 0 of 0xF (last) gives res_count=4, res_words=1.

Source files
------------

// File: rtl/popcount_rr_sched.sv
// Round-robin scheduler sharing one popcount64 datapath between NUM_REQ burst requesters.
// Optional build macro POPCNT_SAT_EN: saturating accumulator plus sticky res_sat output.
module popcount_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ACC_W   = 16,
    parameter int WCNT_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*64-1:0]   req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ACC_W-1:0]        res_count,
    output logic [WCNT_W-1:0]       res_words,
    output logic [ID_W-1:0]         res_id,
    output logic                    busy
`ifdef POPCNT_SAT_EN
    ,
    output logic                    res_sat
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t              state_q;
    logic [ID_W-1:0]     grant_q;
    logic [ID_W-1:0]     last_grant_q;
    logic [ACC_W-1:0]    acc_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                res_valid_q;
    logic [ACC_W-1:0]    res_count_q;
    logic [WCNT_W-1:0]   res_words_q;
    logic [ID_W-1:0]     res_id_q;
    logic                busy_q;

    logic [ACC_W-1:0]    acc_d;
    logic [WCNT_W-1:0]   wcnt_d;
    logic [63:0]         word_s;
    logic [6:0]          pop_s;
    logic [ACC_W:0]      sum_s;
    logic                hs_s;
    logic                pick_vld_s;
    logic [ID_W-1:0]     pick_s;
    int                  arb_idx_s;
`ifdef POPCNT_SAT_EN
    logic                sat_q;
    logic                ovf_s;
`endif

    function automatic logic [6:0] popcount64(input logic [63:0] w);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(w[i]);
        end
        return c;
    endfunction

    // Round-robin pick: descending scan so the smallest offset from last_grant wins.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_s     = '0;
        arb_idx_s  = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            arb_idx_s = (int'(last_grant_q) + i) % NUM_REQ;
            if (req_valid[arb_idx_s]) begin
                pick_vld_s = 1'b1;
                pick_s     = ID_W'(arb_idx_s);
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Shared popcount datapath on the granted requester's word.
    always_comb begin
        word_s = req_data[{grant_q, 6'd0} +: 64];
        pop_s  = popcount64(word_s);
        sum_s  = {1'b0, acc_q} + {{(ACC_W-6){1'b0}}, pop_s};
        wcnt_d = wcnt_q + {{(WCNT_W-1){1'b0}}, 1'b1};
        hs_s   = (state_q == ACCUM) && req_valid[grant_q];
`ifdef POPCNT_SAT_EN
        ovf_s  = sum_s[ACC_W];
        if (sum_s[ACC_W]) begin
            acc_d = '1;
        end else begin
            acc_d = sum_s[ACC_W-1:0];
        end
`else
        acc_d  = sum_s[ACC_W-1:0];
`endif
    end

    // Ready decoded only from state and grant, never from req_valid.
    always_comb begin
        req_ready = '0;
        if (state_q == ACCUM) begin
            req_ready[grant_q] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Scheduler FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            acc_q        <= '0;
            wcnt_q       <= '0;
            res_valid_q  <= 1'b0;
            res_count_q  <= '0;
            res_words_q  <= '0;
            res_id_q     <= '0;
            busy_q       <= 1'b0;
`ifdef POPCNT_SAT_EN
            sat_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld_s) begin
                        grant_q <= pick_s;
                        acc_q   <= '0;
                        wcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
`ifdef POPCNT_SAT_EN
                        sat_q   <= 1'b0;
`endif
                    end
                end
                ACCUM: begin
                    if (hs_s) begin
                        acc_q  <= acc_d;
                        wcnt_q <= wcnt_d;
`ifdef POPCNT_SAT_EN
                        sat_q  <= sat_q | ovf_s;
`endif
                        if (req_last[grant_q]) begin
                            res_count_q <= acc_d;
                            res_words_q <= wcnt_d;
                            res_id_q    <= grant_q;
                            res_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid_q  <= 1'b0;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_words = res_words_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
`ifdef POPCNT_SAT_EN
    assign res_sat   = sat_q;
`endif

endmodule

// File: tb/tb_popcount_rr_sched.sv
// Bench for popcount_rr_sched: directed table, multi-cycle corner sequences and random bursts
// against a burst-level round-robin model; a second ACC_W=8 instance covers wrap/saturation.
module tb_popcount_rr_sched;

    localparam int NR  = 4;
    localparam int IDW = 2;
    localparam int AW  = 16;
    localparam int WW  = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*64-1:0]  req_data = '0;
    logic [NR-1:0]     req_last = '0;
    logic              res_ready = 1'b0;
    logic [NR-1:0]     req_ready, req_ready8;
    logic              res_valid, res_valid8, busy, busy8;
    logic [AW-1:0]     res_count;
    logic [7:0]        res_count8;
    logic [WW-1:0]     res_words, res_words8;
    logic [IDW-1:0]    res_id, res_id8;
`ifdef POPCNT_SAT_EN
    logic              res_sat, res_sat8;
`endif

    always #5 clk = ~clk;

    popcount_rr_sched #(.NUM_REQ(NR), .ID_W(IDW), .ACC_W(AW), .WCNT_W(WW)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_count(res_count), .res_words(res_words),
        .res_id(res_id), .busy(busy)
`ifdef POPCNT_SAT_EN
        , .res_sat(res_sat)
`endif
    );

    popcount_rr_sched #(.NUM_REQ(NR), .ID_W(IDW), .ACC_W(8), .WCNT_W(WW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready8), .res_valid(res_valid8),
        .res_ready(res_ready), .res_count(res_count8), .res_words(res_words8),
        .res_id(res_id8), .busy(busy8)
`ifdef POPCNT_SAT_EN
        , .res_sat(res_sat8)
`endif
    );

    typedef struct {
        int id; int c16; int c8; bit s16; bit s8; int words;
    } exp_t;

    typedef struct {
        int id; int n; logic [4:0][63:0] w; int c16; int c8; bit s8; int words;
    } vec_t;

    logic [63:0] bdat [NR][8];
    int          blen [NR];
    int          bpos [NR];
    bit          act  [NR];
    int          gap_pos [NR];
    int          gap_cnt [NR];
    exp_t        exp_q [$];
    int          last_g;
    int          got_id, got_c16, got_c8, got_words, first_id;
    bit          got_s8;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check_eq(input string nm, input longint a, input longint e);
        n_chk++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, a, e);
    endtask

    // Burst total under wrap (default) or saturation (macro) at modulus modv.
    function automatic int fold(input int j, input int modv, output bit sat);
        int a, t;
        a = 0;
        sat = 1'b0;
        for (int i = 0; i < blen[j]; i++) begin
            t = a + $countones(bdat[j][i]);
`ifdef POPCNT_SAT_EN
            if (t > modv - 1) begin a = modv - 1; sat = 1'b1; end
            else a = t;
`else
            a = t % modv;
`endif
        end
        return a;
    endfunction

    // Every requester in m waits with valid held, so they are served round-robin from last_g+1.
    task automatic build_expected(input logic [NR-1:0] m);
        int g, j;
        bit f;
        logic [NR-1:0] mm;
        exp_t e;
        g = last_g;
        mm = m;
        while (mm != '0) begin
            f = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                j = (g + i) % NR;
                if (!f && mm[j]) begin
                    f = 1'b1;
                    mm[j] = 1'b0;
                    e.id = j;
                    e.c16 = fold(j, 65536, e.s16);
                    e.c8 = fold(j, 256, e.s8);
                    e.words = blen[j] % 1024;
                    exp_q.push_back(e);
                end
            end
            g = exp_q[$].id;
        end
        last_g = g;
    endtask

    task automatic clear_bursts();
        for (int k = 0; k < NR; k++) begin
            act[k] = 1'b0; blen[k] = 0; bpos[k] = 0; gap_pos[k] = 0; gap_cnt[k] = 0;
        end
    endtask

    task automatic set_burst(input int k, input int n);
        act[k] = 1'b1; blen[k] = n; bpos[k] = 0;
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int k = 0; k < NR; k++) if (act[k] && bpos[k] < blen[k]) p = 1'b1;
        return p;
    endfunction

    // Drives requester bursts cycle by cycle and checks every result against exp_q.
    task automatic run_engine(input int budget, input int bub, input int rdy, input int hold);
        int cyc, out_cnt;
        bit rise_due, prev_wait, first;
        logic [AW-1:0] h_cnt;
        logic [WW-1:0] h_words;
        logic [IDW-1:0] h_id;
        logic [NR-1:0] hs, oh;
        exp_t e;
        cyc = 0; out_cnt = 0; rise_due = 0; prev_wait = 0; first = 1;
        h_cnt = '0; h_words = '0; h_id = '0;
        while ((pending() || exp_q.size() > 0) && cyc < budget) begin
            for (int k = 0; k < NR; k++) begin
                if (act[k] && bpos[k] < blen[k]) begin
                    req_valid[k] = 1'b1;
                    if (req_ready[k]) begin
                        if (gap_cnt[k] > 0 && bpos[k] == gap_pos[k]) begin
                            req_valid[k] = 1'b0; gap_cnt[k]--;
                        end else if ($urandom_range(99) < bub) req_valid[k] = 1'b0;
                    end
                    req_data[k*64 +: 64] = bdat[k][bpos[k]];
                    req_last[k] = (bpos[k] == blen[k] - 1);
                end else begin
                    req_valid[k] = 1'b0; req_last[k] = 1'b0; req_data[k*64 +: 64] = 64'h0;
                end
            end
            if (res_valid && out_cnt < hold) res_ready = 1'b0;
            else res_ready = ($urandom_range(99) < rdy);
            @(negedge clk);
            if (rise_due) check_eq("latency_res_valid", res_valid, 1);
            rise_due = 1'b0;
            if (prev_wait) begin
                check_eq("hold_count", res_count, h_cnt);
                check_eq("hold_words", res_words, h_words);
                check_eq("hold_id", res_id, h_id);
            end
            if (res_valid) begin
                check_eq("out_ready_zero", req_ready, 0);
                out_cnt++;
            end else if (exp_q.size() > 0) begin
                oh = '0; oh[exp_q[0].id] = 1'b1;
                check_eq("grant_lock", req_ready & ~oh, 0);
            end
            prev_wait = res_valid && !res_ready;
            h_cnt = res_count; h_words = res_words; h_id = res_id;
            hs = req_valid & req_ready;
            for (int k = 0; k < NR; k++) begin
                if (hs[k]) begin
                    if (req_last[k]) rise_due = 1'b1;
                    bpos[k]++;
                end
            end
            if (res_valid && res_ready) begin
                out_cnt = 0;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res_id", res_id, e.id);
                    check_eq("res_count", res_count, e.c16);
                    check_eq("res_words", res_words, e.words);
                    check_eq("res_count_acc8", res_count8, e.c8);
`ifdef POPCNT_SAT_EN
                    check_eq("res_sat", res_sat, e.s16);
                    check_eq("res_sat_acc8", res_sat8, e.s8);
`endif
                    if (first) first_id = res_id;
                    first = 1'b0;
                    got_id = res_id; got_c16 = res_count; got_c8 = res_count8;
                    got_words = res_words;
`ifdef POPCNT_SAT_EN
                    got_s8 = res_sat8;
`else
                    got_s8 = 1'b0;
`endif
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= budget) begin
            check_eq("engine_timeout", cyc, budget - 1);
            exp_q.delete();
        end
        req_valid = '0; req_last = '0; res_ready = 1'b0;
    endtask

    vec_t tbl [5];
    logic [NR-1:0] m;
    int hsn, cyc;

    initial begin
        tbl[0].id = 2; tbl[0].n = 3; tbl[0].w = '0;
        tbl[0].w[0] = 64'h0; tbl[0].w[1] = 64'h1; tbl[0].w[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        tbl[0].c16 = 65; tbl[0].c8 = 65; tbl[0].s8 = 1'b0; tbl[0].words = 3;
        tbl[1].id = 0; tbl[1].n = 2; tbl[1].w = '0;
        tbl[1].w[0] = 64'hAAAA_AAAA_AAAA_AAAA; tbl[1].w[1] = 64'hAAAA_AAAA_AAAA_AAAA;
        tbl[1].c16 = 64; tbl[1].c8 = 64; tbl[1].s8 = 1'b0; tbl[1].words = 2;
        tbl[2].id = 3; tbl[2].n = 1; tbl[2].w = '0; tbl[2].w[0] = 64'hF;
        tbl[2].c16 = 4; tbl[2].c8 = 4; tbl[2].s8 = 1'b0; tbl[2].words = 1;
        tbl[3].id = 1; tbl[3].n = 5; tbl[3].w = '1;
        tbl[3].c16 = 320;
`ifdef POPCNT_SAT_EN
        tbl[3].c8 = 255; tbl[3].s8 = 1'b1;
`else
        tbl[3].c8 = 64; tbl[3].s8 = 1'b0;
`endif
        tbl[3].words = 5;
        tbl[4].id = 2; tbl[4].n = 4; tbl[4].w = '0;
        tbl[4].w[0] = 64'h8000_0000_0000_0001; tbl[4].w[1] = 64'h3; tbl[4].w[2] = 64'h7;
        tbl[4].c16 = 7; tbl[4].c8 = 7; tbl[4].s8 = 1'b0; tbl[4].words = 4;

        last_g = NR - 1;
        first_id = -1;
        clear_bursts();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_count", res_count, 0);
        check_eq("rst_res_words", res_words, 0);
        check_eq("rst_res_id", res_id, 0);
        check_eq("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;

        // Round-robin from reset: 0,1,2,3 then 0 again.
        for (int k = 0; k < NR; k++) begin bdat[k][0] = 64'h3; set_burst(k, 1); end
        build_expected(4'b1111);
        run_engine(400, 0, 100, 0);
        check_eq("rr_first_after_reset", first_id, 0);
        clear_bursts(); bdat[0][0] = 64'h3; set_burst(0, 1);
        build_expected(4'b0001);
        run_engine(100, 0, 100, 0);
        check_eq("rr_wrap_to_0", got_id, 0);
        clear_bursts(); bdat[1][0] = 64'h3; set_burst(1, 1);
        build_expected(4'b0010);
        run_engine(100, 0, 100, 0);
        clear_bursts();
        bdat[1][0] = 64'h5; set_burst(1, 1);
        bdat[3][0] = 64'h6; set_burst(3, 1);
        build_expected(4'b1010);
        run_engine(200, 0, 100, 0);
        check_eq("rr_skip_to_3", first_id, 3);

        for (int v = 0; v < 5; v++) begin
            clear_bursts();
            for (int i = 0; i < tbl[v].n; i++) bdat[tbl[v].id][i] = tbl[v].w[i];
            set_burst(tbl[v].id, tbl[v].n);
            build_expected(NR'(1) << tbl[v].id);
            run_engine(200, 0, 100, 0);
            check_eq("tbl_id", got_id, tbl[v].id);
            check_eq("tbl_count", got_c16, tbl[v].c16);
            check_eq("tbl_count_acc8", got_c8, tbl[v].c8);
            check_eq("tbl_words", got_words, tbl[v].words);
            check_eq("tbl_sat_acc8", got_s8, tbl[v].s8);
        end

        // Grant lock: req 0 stalls 3 cycles mid-burst while req 1 waits.
        clear_bursts();
        bdat[0][0] = 64'h0F; bdat[0][1] = 64'hFF00; bdat[0][2] = 64'h1;
        set_burst(0, 3); gap_pos[0] = 1; gap_cnt[0] = 3;
        bdat[1][0] = 64'h7; set_burst(1, 1);
        build_expected(4'b0011);
        run_engine(300, 0, 100, 0);

        // Back-pressure: each result held 5 cycles with a competitor waiting.
        clear_bursts();
        bdat[0][0] = 64'h3; set_burst(0, 1);
        bdat[2][0] = 64'hFF; set_burst(2, 1);
        build_expected(4'b0101);
        run_engine(300, 0, 100, 5);

        for (int it = 0; it < 30; it++) begin
            clear_bursts();
            m = NR'($urandom_range(1, 15));
            for (int k = 0; k < NR; k++) begin
                if (m[k]) begin
                    hsn = $urandom_range(1, 5);
                    for (int i = 0; i < hsn; i++) begin
                        if ($urandom_range(7) == 0) bdat[k][i] = 64'hFFFF_FFFF_FFFF_FFFF;
                        else bdat[k][i] = {$urandom, $urandom};
                    end
                    set_burst(k, hsn);
                    gap_pos[k] = $urandom_range(0, hsn - 1);
                    gap_cnt[k] = $urandom_range(0, 2);
                end
            end
            build_expected(m);
            run_engine(1000, 20, 70, $urandom_range(0, 2));
        end

        // Reset mid-burst after two accepted words.
        clear_bursts();
        for (int i = 0; i < 4; i++) bdat[0][i] = {$urandom, $urandom};
        req_valid = 4'b0001; req_last = '0; req_data[63:0] = bdat[0][0]; res_ready = 1'b1;
        hsn = 0; cyc = 0;
        while (hsn < 2 && cyc < 50) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) hsn++;
            @(posedge clk); #1;
            req_data[63:0] = bdat[0][hsn];
            cyc++;
        end
        check_eq("rst_mid_handshakes", hsn, 2);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_res_valid", res_valid, 0);
        check_eq("rst_mid_req_ready", req_ready, 0);
        check_eq("rst_mid_busy_acc8", busy8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req_valid = '0;
        last_g = NR - 1;
        bdat[0][0] = 64'hF; set_burst(0, 1);
        build_expected(4'b0001);
        run_engine(100, 0, 100, 0);
        check_eq("post_rst_count", got_c16, 4);
        check_eq("post_rst_words", got_words, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
